md_hazard_ctrl: RTL and testbench
=================================

MD_HAZARD_CTRL -- requirements
Module: md_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock, clk; reset is synchronous and active-high, named reset.
REQ-002 Port list SHALL be, clock and reset first:
  clk  in  1  pipeline clock, posedge active
  reset  in  1  synchronous active-high reset
  d_mdOp  in  4  mult/div op of the instruction in D
  e_mdOp  in  4  mult/div op of the instruction in E
  d_rs, d_rt  in  5 each  source register numbers in D
  d_rs_tuse, d_rt_tuse  in  2 each  cycles until D needs rs/rt (3 = never)
  e_A3, m_A3  in  5 each  destination registers in E/M
  e_RegWrite, m_RegWrite  in  1 each  write enables in E/M
  e_tnew, m_tnew  in  2 each  cycles until the E/M result is ready
  md_start  out  1  starts the MDU this cycle
  md_busy  out  1  MDU computing
  stall  out  1  freeze the front end
  pc_en, fd_en  out  1 each  PC / F-D register enables
  de_clr  out  1  flush D-E register (bubble)

Function
REQ-003 mdOp encoding SHALL be: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; codes 9-15 count as none.
REQ-004 md_start SHALL be combinational: 1 iff e_mdOp is in 1..4.
REQ-005 A 4-bit down-counter cnt SHALL load MULT_CYC (5) at a posedge where md_start=1 for mult/multu, or DIV_CYC (10) for div/divu.
REQ-006 When md_start=0 and cnt!=0, cnt SHALL decrement by 1 per cycle; it SHALL hold at 0, never wrap.
REQ-007 md_busy SHALL equal (cnt != 0), registered, so busy is 1 for exactly MULT_CYC/DIV_CYC cycles after the start cycle.
REQ-008 If md_start=1 while cnt!=0, cnt SHALL reload with the new latency; the last start wins.
REQ-009 md_stall SHALL be 1 iff d_mdOp is in 1..8 and (md_start or md_busy).
REQ-010 rs_stall SHALL be 1 iff d_rs!=0 and either (d_rs==e_A3, e_RegWrite, d_rs_tuse<e_tnew) or (d_rs==m_A3, m_RegWrite, d_rs_tuse<m_tnew); rt_stall SHALL be defined the same way with d_rt.
REQ-011 stall SHALL be md_stall | rs_stall | rt_stall, combinational, with no cycle of latency.
REQ-012 pc_en and fd_en SHALL equal ~stall, and de_clr SHALL equal stall.
REQ-013 E/M/W SHALL never be stalled by this block, so md_start SHALL assert even in a cycle where stall=1.
REQ-014 The counter SHALL be the only state; all other outputs SHALL be combinational from the inputs and cnt.

Reset
REQ-015 At a posedge with reset=1, cnt SHALL go to 0, so md_busy=0 in the next cycle; reset SHALL take priority over md_start.
REQ-016 Reset in the middle of a divide SHALL abort it; stall SHALL then reflect only the combinational terms.
REQ-017 After reset, with all inputs 0, outputs SHALL be md_start=0, md_busy=0, stall=0, pc_en=1, fd_en=1, de_clr=0.

Structure
REQ-018 A shared package SHALL hold the mdOp codes, MULT_CYC=5, DIV_CYC=10, TUSE_NEVER=3 and the counter width.
REQ-019 One sub-module, md_busy_cnt, SHALL hold the counter (REQ-005..008, 015); the stall decode SHALL stay in the top.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
  V1: e_mdOp=1 for one cycle -> md_start=1 that cycle; md_busy=1 for the next 5 cycles, then 0.
  V2: e_mdOp=3, then d_mdOp=6 held -> stall=1, de_clr=1, pc_en=0 for the start cycle plus 10 busy cycles; released on cycle 12.
  V3: d_rs=8, d_rs_tuse=0, e_A3=8, e_RegWrite=1, e_tnew=2 -> stall=1; with e_tnew=0 -> stall=0; with d_rs=0 -> stall=0.
  V4: reset=1 at busy cycle 4 of a div -> md_busy=0 the next cycle; d_mdOp=5 -> stall=0.
  V5: e_mdOp=1 at cycle 0, e_mdOp=4 at cycle 2 -> cnt reloads 10; busy through cycle 12.
  V6: e_mdOp=9 -> md_start=0, md_busy stays 0.

Source files
------------

// File: rtl/md_hazard_ctrl_pkg.sv
// Shared definitions for the mult/div hazard controller: op codes,
// MDU latencies, the "never used" Tuse marker and the counter width.
package md_hazard_ctrl_pkg;

    localparam int CNT_W = 4;

    localparam logic [CNT_W-1:0] MULT_CYC   = 4'd5;
    localparam logic [CNT_W-1:0] DIV_CYC    = 4'd10;
    localparam logic [1:0]       TUSE_NEVER = 2'd3;

    // Codes 9..15 are not listed and behave exactly like MD_NONE.
    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

    // True for the four ops that launch a multi-cycle MDU computation.
    function automatic logic md_is_start_op(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

    // True for any op that touches the MDU or HI/LO.
    function automatic logic md_is_mdu_op(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd8);
    endfunction

    // Busy length launched by an op; zero for anything that does not start.
    function automatic logic [CNT_W-1:0] md_latency(input logic [3:0] op);
        logic [CNT_W-1:0] lat;
        lat = '0;
        if ((op == MD_MULT) || (op == MD_MULTU)) begin
            lat = MULT_CYC;
        end else if ((op == MD_DIV) || (op == MD_DIVU)) begin
            lat = DIV_CYC;
        end
        return lat;
    endfunction

endpackage

// File: rtl/md_hazard_ctrl_busy_cnt.sv
// MDU busy counter: loads the op latency on a start, counts down to zero
// and saturates there. md_busy is high while the count is non-zero.
module md_busy_cnt
    import md_hazard_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       md_start,
    input  logic [3:0] start_op,
    output logic       md_busy
);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Next count: a new start always reloads (last start wins), else decrement to 0.
    always_comb begin
        cnt_d = cnt_q;
        if (md_start) begin
            cnt_d = md_latency(start_op);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register; reset aborts any computation in flight and beats a start.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign md_busy = (cnt_q != '0);

endmodule

// File: rtl/md_hazard_ctrl.sv
// Front-end hazard controller: freezes F/D and bubbles D->E when D needs
// a result that is not ready yet or touches a busy MDU. E/M/W keep flowing,
// so an MDU start in E is issued regardless of the stall.
module md_hazard_ctrl
    import md_hazard_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] d_mdOp,
    input  logic [3:0] e_mdOp,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_rs_tuse,
    input  logic [1:0] d_rt_tuse,
    input  logic [4:0] e_A3,
    input  logic [4:0] m_A3,
    input  logic       e_RegWrite,
    input  logic       m_RegWrite,
    input  logic [1:0] e_tnew,
    input  logic [1:0] m_tnew,
    output logic       md_start,
    output logic       md_busy,
    output logic       stall,
    output logic       pc_en,
    output logic       fd_en,
    output logic       de_clr
);

    logic md_stall;
    logic rs_stall;
    logic rt_stall;

    assign md_start = md_is_start_op(e_mdOp);

    md_busy_cnt u_busy_cnt (
        .clk      (clk),
        .reset    (reset),
        .md_start (md_start),
        .start_op (e_mdOp),
        .md_busy  (md_busy)
    );

    // MDU structural hazard: D touches HI/LO while the MDU is launching or busy.
    always_comb begin
        md_stall = 1'b0;
        if (md_is_mdu_op(d_mdOp) && (md_start || md_busy)) begin
            md_stall = 1'b1;
        end
    end

    // Data hazard on rs: a producer in E or M finishes later than D needs it.
    // $0 is never a real dependency; a Tuse of "never" can never stall.
    always_comb begin
        rs_stall = 1'b0;
        if ((d_rs != 5'd0) && (d_rs_tuse != TUSE_NEVER)) begin
            if ((d_rs == e_A3) && e_RegWrite && (d_rs_tuse < e_tnew)) begin
                rs_stall = 1'b1;
            end
            if ((d_rs == m_A3) && m_RegWrite && (d_rs_tuse < m_tnew)) begin
                rs_stall = 1'b1;
            end
        end
    end

    // Data hazard on rt, same rule as rs.
    always_comb begin
        rt_stall = 1'b0;
        if ((d_rt != 5'd0) && (d_rt_tuse != TUSE_NEVER)) begin
            if ((d_rt == e_A3) && e_RegWrite && (d_rt_tuse < e_tnew)) begin
                rt_stall = 1'b1;
            end
            if ((d_rt == m_A3) && m_RegWrite && (d_rt_tuse < m_tnew)) begin
                rt_stall = 1'b1;
            end
        end
    end

    // Front-end controls: hold PC and F/D, inject a bubble into D/E.
    always_comb begin
        stall  = md_stall | rs_stall | rt_stall;
        pc_en  = ~stall;
        fd_en  = ~stall;
        de_clr = stall;
    end

endmodule

// File: tb/tb_md_hazard_ctrl.sv
// Directed bench for md_hazard_ctrl. Inputs change 1 time unit after each
// posedge; outputs are compared at the following negedge against vectors
// {md_start, md_busy, stall, pc_en, fd_en, de_clr} queued by the stimulus.
module tb_md_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] d_mdOp, e_mdOp;
    logic [4:0] d_rs, d_rt, e_A3, m_A3;
    logic [1:0] d_rs_tuse, d_rt_tuse, e_tnew, m_tnew;
    logic       e_RegWrite, m_RegWrite;
    logic       md_start, md_busy, stall, pc_en, fd_en, de_clr;

    int n_checks = 0;
    int n_errors = 0;
    logic [5:0] exp_q[$];

    md_hazard_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .d_mdOp     (d_mdOp),
        .e_mdOp     (e_mdOp),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_rs_tuse  (d_rs_tuse),
        .d_rt_tuse  (d_rt_tuse),
        .e_A3       (e_A3),
        .m_A3       (m_A3),
        .e_RegWrite (e_RegWrite),
        .m_RegWrite (m_RegWrite),
        .e_tnew     (e_tnew),
        .m_tnew     (m_tnew),
        .md_start   (md_start),
        .md_busy    (md_busy),
        .stall      (stall),
        .pc_en      (pc_en),
        .fd_en      (fd_en),
        .de_clr     (de_clr)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [5:0] act, input logic [5:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got {start,busy,stall,pc_en,fd_en,de_clr}=%b, expected %b",
                     tag, act, exp);
        end
    endtask

    task automatic clear_inputs();
        d_mdOp = 4'd0; e_mdOp = 4'd0;
        d_rs = 5'd0; d_rt = 5'd0; e_A3 = 5'd0; m_A3 = 5'd0;
        d_rs_tuse = 2'd3; d_rt_tuse = 2'd3; e_tnew = 2'd0; m_tnew = 2'd0;
        e_RegWrite = 1'b0; m_RegWrite = 1'b0;
    endtask

    // One cycle: queue the expectation, compare at negedge, advance past posedge.
    task automatic cyc(input string tag, input logic s, input logic b, input logic st);
        logic [5:0] e;
        exp_q.push_back({s, b, st, ~st, ~st, st});
        @(negedge clk);
        e = exp_q.pop_front();
        check(tag, {md_start, md_busy, stall, pc_en, fd_en, de_clr}, e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state with all-zero inputs
        d_rs_tuse = 2'd0; d_rt_tuse = 2'd0;
        cyc("reset_idle", 1'b0, 1'b0, 1'b0);
        clear_inputs();

        // V1: mult start, 5 busy cycles
        e_mdOp = 4'd1;
        cyc("v1_start", 1'b1, 1'b0, 1'b0);
        e_mdOp = 4'd0;
        for (int i = 1; i <= 5; i++) cyc($sformatf("v1_busy%0d", i), 1'b0, 1'b1, 1'b0);
        cyc("v1_done", 1'b0, 1'b0, 1'b0);

        // V2: div start with mflo waiting in D
        e_mdOp = 4'd3; d_mdOp = 4'd6;
        cyc("v2_start", 1'b1, 1'b0, 1'b1);
        e_mdOp = 4'd0;
        for (int i = 1; i <= 10; i++) cyc($sformatf("v2_busy%0d", i), 1'b0, 1'b1, 1'b1);
        cyc("v2_release", 1'b0, 1'b0, 1'b0);
        clear_inputs();

        // V3: register data hazards
        d_rs = 5'd8; d_rs_tuse = 2'd0; e_A3 = 5'd8; e_RegWrite = 1'b1; e_tnew = 2'd2;
        cyc("v3_rs_e_stall", 1'b0, 1'b0, 1'b1);
        e_tnew = 2'd0;
        cyc("v3_rs_e_ready", 1'b0, 1'b0, 1'b0);
        e_tnew = 2'd2; d_rs = 5'd0; e_A3 = 5'd0;
        cyc("v3_rs_zero", 1'b0, 1'b0, 1'b0);
        d_rs = 5'd8; e_A3 = 5'd8; d_rs_tuse = 2'd2;
        cyc("v3_tuse_eq_tnew", 1'b0, 1'b0, 1'b0);
        d_rs_tuse = 2'd1;
        cyc("v3_tuse_lt_tnew", 1'b0, 1'b0, 1'b1);
        e_RegWrite = 1'b0;
        cyc("v3_no_regwrite", 1'b0, 1'b0, 1'b0);
        e_RegWrite = 1'b1; e_tnew = 2'd3; d_rs_tuse = 2'd3;
        cyc("v3_tuse_never", 1'b0, 1'b0, 1'b0);
        clear_inputs();
        d_rt = 5'd5; d_rt_tuse = 2'd1; m_A3 = 5'd5; m_RegWrite = 1'b1; m_tnew = 2'd2;
        cyc("v3_rt_m_stall", 1'b0, 1'b0, 1'b1);
        m_A3 = 5'd6;
        cyc("v3_rt_m_other", 1'b0, 1'b0, 1'b0);
        clear_inputs();

        // V4: reset mid-divide aborts it
        e_mdOp = 4'd3;
        cyc("v4_start", 1'b1, 1'b0, 1'b0);
        e_mdOp = 4'd0;
        for (int i = 1; i <= 3; i++) cyc($sformatf("v4_busy%0d", i), 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        cyc("v4_busy4_reset", 1'b0, 1'b1, 1'b0);
        reset = 1'b0; d_mdOp = 4'd5;
        cyc("v4_after_reset", 1'b0, 1'b0, 1'b0);
        clear_inputs();

        // Reset beats a simultaneous start
        reset = 1'b1; e_mdOp = 4'd1;
        cyc("rst_prio_start", 1'b1, 1'b0, 1'b0);
        reset = 1'b0; e_mdOp = 4'd0;
        cyc("rst_prio_after", 1'b0, 1'b0, 1'b0);

        // V5: mult then divu two cycles later reloads the counter
        e_mdOp = 4'd1;
        cyc("v5_c0", 1'b1, 1'b0, 1'b0);
        e_mdOp = 4'd0;
        cyc("v5_c1", 1'b0, 1'b1, 1'b0);
        e_mdOp = 4'd4;
        cyc("v5_c2", 1'b1, 1'b1, 1'b0);
        e_mdOp = 4'd0;
        for (int i = 3; i <= 12; i++) cyc($sformatf("v5_c%0d", i), 1'b0, 1'b1, 1'b0);
        cyc("v5_c13", 1'b0, 1'b0, 1'b0);

        // V6: undefined op codes do nothing
        e_mdOp = 4'd9;
        cyc("v6_op9", 1'b0, 1'b0, 1'b0);
        e_mdOp = 4'd15;
        cyc("v6_op15", 1'b0, 1'b0, 1'b0);
        e_mdOp = 4'd0;
        cyc("v6_after", 1'b0, 1'b0, 1'b0);

        // Start issues even while D stalls; D op decode boundaries while busy
        e_mdOp = 4'd1; d_mdOp = 4'd1;
        cyc("dd_start_stall", 1'b1, 1'b0, 1'b1);
        e_mdOp = 4'd0; d_mdOp = 4'd9;
        cyc("dd_op9_busy", 1'b0, 1'b1, 1'b0);
        d_mdOp = 4'd8;
        cyc("dd_op8_busy", 1'b0, 1'b1, 1'b1);
        d_mdOp = 4'd0;
        for (int i = 3; i <= 5; i++) cyc($sformatf("dd_busy%0d", i), 1'b0, 1'b1, 1'b0);
        d_mdOp = 4'd8;
        cyc("dd_op8_idle", 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
